// File: rtl/dist_to_disp_if.sv
// Request/result handshake bundle for dist_to_disp; out_err exists only with DIST2DISP_ERR_EN.
interface dist_to_disp_if #(
  parameter int DIST_W = 12,
  parameter int DISP_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DIST_W-1:0] in_dist;
  logic              out_valid;
  logic              out_ready;
  logic [DISP_W-1:0] out_disp;
`ifdef DIST2DISP_ERR_EN
  logic [DIST_W-1:0] out_err;

  modport master (
    output in_valid, in_dist, out_ready,
    input  in_ready, out_valid, out_disp, out_err
  );
  modport slave (
    input  in_valid, in_dist, out_ready,
    output in_ready, out_valid, out_disp, out_err
  );
`else
  modport master (
    output in_valid, in_dist, out_ready,
    input  in_ready, out_valid, out_disp
  );
  modport slave (
    input  in_valid, in_dist, out_ready,
    output in_ready, out_valid, out_disp
  );
`endif
endinterface

// File: rtl/dist_to_disp.sv
// Distance -> nearest disparity by linear search, one candidate per clock; result held until out_ready,
// no new request while busy or holding. DIST2DISP_ERR_EN adds the out_err residual output.
module dist_to_disp #(
  parameter int DIST_W   = 12,
  parameter int DISP_W   = 6,
  parameter int MAX_DISP = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  dist_to_disp_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DISP_W-1:0] cand, cand_nxt;
  logic [DISP_W-1:0] best_disp, best_disp_nxt;
  logic [DISP_W-1:0] disp_q;
  logic [DIST_W-1:0] target, target_nxt;
  logic [DIST_W-1:0] best_err, best_err_nxt;
  logic [DIST_W-1:0] cand_dist, cur_err;
  logic              search_end;
  logic              load_out;

  // Fixed disparity->distance table; entry 0 is the invalid disparity.
  function automatic logic [DIST_W-1:0] table_dist(input logic [DISP_W-1:0] d);
    int unsigned di;
    int unsigned r;
    di = 32'(d);
    if (di == 0)       r = 0;
    else if (di <= 42) r = 100 - di;
    else if (di <= 57) r = 99 - di;
    else if (di <= 60) r = 100 - di;
    else               r = 101 - di;
    return DIST_W'(r);
  endfunction

  assign cand_dist  = table_dist(cand);
  assign cur_err    = (cand_dist > target) ? (cand_dist - target) : (target - cand_dist);
  assign search_end = (cur_err == '0) || (cand == DISP_W'(MAX_DISP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      target    <= '0;
      best_disp <= '0;
      best_err  <= '0;
      disp_q    <= '0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      target    <= target_nxt;
      best_disp <= best_disp_nxt;
      best_err  <= best_err_nxt;
      if (load_out) disp_q <= best_disp_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    target_nxt    = target;
    best_disp_nxt = best_disp;
    best_err_nxt  = best_err;
    load_out      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          target_nxt    = bus.in_dist;
          best_disp_nxt = '0;
          if (bus.in_dist == '0) begin
            best_err_nxt = '0;
            load_out     = 1'b1;
            state_nxt    = DONE;
          end else begin
            best_err_nxt = '1;
            cand_nxt     = DISP_W'(1);
            state_nxt    = SEARCH;
          end
        end
      end
      SEARCH: begin
        // Strict compare: on a tie the earlier (smaller) disparity wins.
        if (cur_err < best_err) begin
          best_err_nxt  = cur_err;
          best_disp_nxt = cand;
        end
        if (search_end) begin
          load_out  = 1'b1;
          state_nxt = DONE;
        end else begin
          cand_nxt = cand + DISP_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_disp  = disp_q;

`ifdef DIST2DISP_ERR_EN
  logic [DIST_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            err_q <= '0;
    else if (load_out)                     err_q <= best_err_nxt;
    else if (state == DONE && bus.out_ready) err_q <= '0;
  end

  assign bus.out_err = err_q;
`endif

endmodule

// File: tb/tb_dist_to_disp.sv
// Directed and random requests against a search-free reference built from the distance table.
module tb_dist_to_disp;

  localparam int DIST_W   = 12;
  localparam int DISP_W   = 6;
  localparam int MAX_DISP = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tab [0:MAX_DISP];

  always #5 clk = ~clk;

  dist_to_disp_if #(.DIST_W(DIST_W), .DISP_W(DISP_W)) bus ();

  dist_to_disp #(.DIST_W(DIST_W), .DISP_W(DISP_W), .MAX_DISP(MAX_DISP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nearest table entry, smallest disparity on ties; latency counts edges up to the hit.
  function automatic void model(input int t, output int disp, output int err, output int lat);
    int best_e;
    int e;
    disp = 0;
    err  = 0;
    lat  = 1;
    if (t == 0) return;
    best_e = 1 << 30;
    lat    = MAX_DISP + 1;
    for (int d = 1; d <= MAX_DISP; d++) begin
      e = (tab[d] > t) ? tab[d] - t : t - tab[d];
      if (e < best_e) begin
        best_e = e;
        disp   = d;
      end
      if (e == 0) begin
        lat = d + 1;
        break;
      end
    end
    err = best_e;
  endfunction

  // Entered and left just after a falling edge.
  task automatic do_req(input int t, input int hold);
    int exp_disp, exp_err, exp_lat, lat;
    model(t, exp_disp, exp_err, exp_lat);
    check("ready_before_req", bus.in_ready, 1);
    bus.in_dist  = DIST_W'(t);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_dist  = DIST_W'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat > 1) check("busy_ready_low", bus.in_ready, 0);
    end while (!bus.out_valid && lat < 200);
    check("latency", lat, exp_lat);
    check("disp", bus.out_disp, exp_disp);
`ifdef DIST2DISP_ERR_EN
    check("err", bus.out_err, exp_err);
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_dist  = DIST_W'($urandom_range(1, 300));
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_disp", bus.out_disp, exp_disp);
      check("hold_ready_low", bus.in_ready, 0);
`ifdef DIST2DISP_ERR_EN
      check("hold_err", bus.out_err, exp_err);
`endif
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("released_valid", bus.out_valid, 0);
    check("released_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_dist   = '0;
    bus.out_ready = 1'b0;

    tab[0] = 0;
    for (int d = 1; d <= 42; d++) tab[d] = 100 - d;
    for (int d = 43; d <= 57; d++) tab[d] = 99 - d;
    tab[58] = 42; tab[59] = 41; tab[60] = 40;
    tab[61] = 40; tab[62] = 39; tab[63] = 38;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_disp", bus.out_disp, 0);
`ifdef DIST2DISP_ERR_EN
    check("rst_out_err", bus.out_err, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    do_req(99, 0);
    do_req(58, 1);
    do_req(42, 0);
    do_req(57, 10);
    do_req(200, 0);
    do_req(10, 2);
    do_req(0, 3);
    do_req(38, 0);
    do_req(4095, 0);

    // Reset in the middle of a long search.
    bus.in_dist  = DIST_W'(57);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_disp", bus.out_disp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check("postrst_no_valid", bus.out_valid, 0);
    do_req(58, 0);

    for (int i = 0; i < 20; i++) begin
      int t;
      t = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 160));
      do_req(t, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
